// File: rtl/bp_fe_icache_fetch_gen_if.sv
// Fetch request / instruction return bundle between the fetch generator and the I$ test wrapper.
interface bp_fe_icache_fetch_gen_if #(
    parameter int vaddr_width_p = 39,
    parameter int ptag_width_p  = 28,
    parameter int instr_width_p = 32
);
    logic [vaddr_width_p-1:0] vaddr_o;
    logic                     vaddr_v_o;
    logic                     vaddr_ready_i;
    logic [ptag_width_p-1:0]  ptag_o;
    logic                     uncached_o;
    logic [instr_width_p-1:0] data_i;
    logic                     data_v_i;

    modport master (
        output vaddr_o, vaddr_v_o, ptag_o, uncached_o,
        input  vaddr_ready_i, data_i, data_v_i
    );

    modport slave (
        input  vaddr_o, vaddr_v_o, ptag_o, uncached_o,
        output vaddr_ready_i, data_i, data_v_i
    );
endinterface

// File: rtl/bp_fe_icache_fetch_gen.sv
// Sequential PC fetch generator with redirect and in-order return checking against address-valued memory.
// Latency: vaddr_v_o one cycle after start_i; each return checked in its own cycle, error_o registered.
// Backpressure: issue stalls on vaddr_ready_i low or max_outstanding_p in flight; returns are never stalled.
module bp_fe_icache_fetch_gen #(
    parameter int                         vaddr_width_p       = 39,
    parameter int                         ptag_width_p        = 28,
    parameter int                         page_offset_width_p = 12,
    parameter int                         instr_width_p       = 32,
    parameter int                         max_outstanding_p   = 8,
    parameter int                         num_fetches_p       = 64,
    parameter logic [vaddr_width_p-1:0]   start_vaddr_p       = 39'h00_8000_0000,
    parameter logic [ptag_width_p-1:0]    uncached_ptag_min_p = 28'h000_1000
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic                                 start_i,
    input  logic                                 redirect_v_i,
    input  logic [vaddr_width_p-1:0]             redirect_vaddr_i,
    bp_fe_icache_fetch_gen_if.master             fetch,
    output logic [$clog2(num_fetches_p+1)-1:0]   fetch_count_o,
    output logic                                 done_o,
    output logic                                 error_o,
    output logic [vaddr_width_p-1:0]             err_vaddr_o
);
    localparam int cnt_w = $clog2(num_fetches_p + 1);
    localparam int ptr_w = $clog2(max_outstanding_p);
    localparam int occ_w = $clog2(max_outstanding_p + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e                   state_q, state_n;
    logic [vaddr_width_p-1:0] pc_q;
    logic [cnt_w-1:0]         fetch_count_q;
    logic [occ_w-1:0]         outstanding_q, outstanding_n;
    logic [ptr_w-1:0]         wr_ptr_q, rd_ptr_q;
    logic [vaddr_width_p-1:0] track_mem [max_outstanding_p];
    logic                     error_q;
    logic [vaddr_width_p-1:0] err_vaddr_q;

    logic                     vaddr_v;
    logic                     issue;
    logic                     pop;
    logic                     launch;
    logic [vaddr_width_p-1:0] head;
    logic                     err_evt;
    logic [vaddr_width_p-1:0] err_addr;
    logic                     error_base;

    // Identity translation: the tag is simply the address above the page offset.
    assign fetch.vaddr_o    = pc_q;
    assign fetch.ptag_o     = ptag_width_p'(pc_q >> page_offset_width_p);
    assign fetch.uncached_o = (fetch.ptag_o >= uncached_ptag_min_p);
    assign fetch.vaddr_v_o  = vaddr_v;

    assign vaddr_v = (state_q == RUN) && (outstanding_q < occ_w'(max_outstanding_p));
    assign issue   = vaddr_v && fetch.vaddr_ready_i;
    assign pop     = fetch.data_v_i && (outstanding_q != '0);
    assign head    = track_mem[rd_ptr_q];

    // A return with nothing tracked is an error attributed to address 0.
    assign err_evt    = fetch.data_v_i && (!pop || (fetch.data_i != instr_width_p'(head)));
    assign err_addr   = pop ? head : '0;
    assign error_base = launch ? 1'b0 : error_q;

    always_comb begin
        outstanding_n = outstanding_q;
        if (issue && !pop) begin
            outstanding_n = outstanding_q + occ_w'(1);
        end else if (pop && !issue) begin
            outstanding_n = outstanding_q - occ_w'(1);
        end
    end

    always_comb begin
        state_n = state_q;
        launch  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_n = RUN;
                    launch  = 1'b1;
                end
            end
            RUN: begin
                if (issue && (fetch_count_q == cnt_w'(num_fetches_p - 1))) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (outstanding_n == '0) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (start_i) begin
                    state_n = RUN;
                    launch  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            fetch_count_q <= '0;
            outstanding_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            error_q       <= 1'b0;
            err_vaddr_q   <= '0;
        end else begin
            state_q       <= state_n;
            outstanding_q <= outstanding_n;

            if (launch) begin
                pc_q          <= start_vaddr_p;
                fetch_count_q <= '0;
            end else if (state_q == RUN) begin
                // Redirect wins over the increment; a same-cycle issue still used the old pc.
                if (redirect_v_i) begin
                    pc_q <= redirect_vaddr_i & ~vaddr_width_p'(3);
                end else if (issue) begin
                    pc_q <= pc_q + vaddr_width_p'(4);
                end
                if (issue) begin
                    fetch_count_q <= fetch_count_q + cnt_w'(1);
                end
            end

            if (issue) begin
                wr_ptr_q <= wr_ptr_q + ptr_w'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + ptr_w'(1);
            end

            error_q <= error_base || err_evt;
            if (err_evt && !error_base) begin
                err_vaddr_q <= err_addr;
            end else if (launch) begin
                err_vaddr_q <= '0;
            end
        end
    end

    // Tracker storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (issue) begin
            track_mem[wr_ptr_q] <= pc_q;
        end
    end

    assign fetch_count_o = fetch_count_q;
    assign done_o        = (state_q == DONE);
    assign error_o       = error_q;
    assign err_vaddr_o   = err_vaddr_q;
endmodule

// File: tb/tb_bp_fe_icache_fetch_gen.sv
// Bench for bp_fe_icache_fetch_gen: wrapper model returning address-valued instructions two cycles after issue.
module tb_bp_fe_icache_fetch_gen;
    typedef struct {
        logic [38:0] addr;
        int          due;
    } ret_t;

    typedef struct {
        logic [38:0] target;
        logic [38:0] exp_vaddr;
        logic [27:0] exp_ptag;
        logic        exp_unc;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        redirect_v;
    logic [38:0] redirect_vaddr;
    logic [6:0]  fetch_count;
    logic        done;
    logic        error;
    logic [38:0] err_vaddr;

    bp_fe_icache_fetch_gen_if #(.vaddr_width_p(39), .ptag_width_p(28), .instr_width_p(32)) ifc ();

    bp_fe_icache_fetch_gen dut (
        .clk_i            (clk),
        .reset_n_i        (rst_n),
        .start_i          (start),
        .redirect_v_i     (redirect_v),
        .redirect_vaddr_i (redirect_vaddr),
        .fetch            (ifc),
        .fetch_count_o    (fetch_count),
        .done_o           (done),
        .error_o          (error),
        .err_vaddr_o      (err_vaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          issue_cnt = 0;
    int          sb_extra = 0;
    logic        hold = 1'b0;
    logic        release1 = 1'b0;
    logic        sb_on = 1'b0;
    logic [38:0] corrupt_a = 39'h1;
    logic [38:0] corrupt_b = 39'h1;
    ret_t        ret_q[$];
    logic [38:0] exp_q[$];
    vec_t        vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: observe the handshake mid-cycle, then update wrapper-side drives just after the edge.
    task automatic step();
        ret_t        r;
        logic [38:0] e;
        logic [27:0] ep;
        @(negedge clk);
        if (ifc.vaddr_v_o && ifc.vaddr_ready_i) begin
            issue_cnt++;
            ret_q.push_back(ret_t'{addr: ifc.vaddr_o, due: cyc + 2});
            if (sb_on) begin
                if (exp_q.size() == 0) begin
                    sb_extra++;
                end else begin
                    e  = exp_q.pop_front();
                    ep = 28'(e >> 12);
                    chk("issue_vaddr", 64'(ifc.vaddr_o), 64'(e));
                    chk("issue_ptag", 64'(ifc.ptag_o), 64'(ep));
                    chk("issue_uncached", 64'(ifc.uncached_o), 64'(ep >= 28'h1000));
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        start        = 1'b0;
        redirect_v   = 1'b0;
        ifc.data_v_i = 1'b0;
        ifc.data_i   = '0;
        if (ret_q.size() != 0 && ((!hold && ret_q[0].due <= cyc) || release1)) begin
            r            = ret_q.pop_front();
            release1     = 1'b0;
            ifc.data_v_i = 1'b1;
            ifc.data_i   = r.addr[31:0] ^ (((r.addr == corrupt_a) || (r.addr == corrupt_b)) ? 32'hDEAD_BEEF : 32'h0);
        end
    endtask

    task automatic run_to_done();
        for (int i = 0; i < 600 && !done; i++) begin
            step();
        end
        chk("done_reached", 64'(done), 64'd1);
    endtask

    initial begin
        int g;
        vecs[0] = '{39'h00_8000_1002, 39'h00_8000_1000, 28'h008_0001, 1'b1};
        vecs[1] = '{39'h00_00FF_F003, 39'h00_00FF_F000, 28'h000_0FFF, 1'b0};
        vecs[2] = '{39'h00_0100_0001, 39'h00_0100_0000, 28'h000_1000, 1'b1};
        vecs[3] = '{39'h00_0000_0ABC, 39'h00_0000_0ABC, 28'h000_0000, 1'b0};
        vecs[4] = '{39'h7F_FFFF_FFFF, 39'h7F_FFFF_FFFC, 28'h7FF_FFFF, 1'b1};

        rst_n             = 1'b0;
        start             = 1'b0;
        redirect_v        = 1'b0;
        redirect_vaddr    = '0;
        ifc.vaddr_ready_i = 1'b0;
        ifc.data_v_i      = 1'b0;
        ifc.data_i        = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vaddr_v", 64'(ifc.vaddr_v_o), 64'd0);
        chk("rst_vaddr", 64'(ifc.vaddr_o), 64'd0);
        chk("rst_ptag", 64'(ifc.ptag_o), 64'd0);
        chk("rst_uncached", 64'(ifc.uncached_o), 64'd0);
        chk("rst_fetch_count", 64'(fetch_count), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_err_vaddr", 64'(err_vaddr), 64'd0);
        rst_n = 1'b1;
        step();

        // Straight-line run with an always-ready wrapper.
        ifc.vaddr_ready_i = 1'b1;
        sb_on = 1'b1;
        for (int i = 0; i < 64; i++) exp_q.push_back(39'h00_8000_0000 + 39'(4 * i));
        issue_cnt = 0;
        start = 1'b1;
        step();
        chk("start_vaddr_v", 64'(ifc.vaddr_v_o), 64'd1);
        chk("start_vaddr", 64'(ifc.vaddr_o), 64'h8000_0000);
        chk("start_fetch_count", 64'(fetch_count), 64'd0);
        run_to_done();
        chk("main_fetch_count", 64'(fetch_count), 64'd64);
        chk("main_issues", 64'(issue_cnt), 64'd64);
        chk("main_error", 64'(error), 64'd0);
        chk("main_vaddr_v_done", 64'(ifc.vaddr_v_o), 64'd0);
        chk("main_sb_left", 64'(exp_q.size()), 64'd0);
        chk("main_sb_extra", 64'(sb_extra), 64'd0);
        sb_on = 1'b0;

        // Credit limit: no returns until released.
        hold = 1'b1;
        issue_cnt = 0;
        start = 1'b1;
        step();
        repeat (20) step();
        chk("credit_issues", 64'(issue_cnt), 64'd8);
        chk("credit_vaddr_v", 64'(ifc.vaddr_v_o), 64'd0);
        chk("credit_fetch_count", 64'(fetch_count), 64'd8);
        release1 = 1'b1;
        repeat (10) step();
        chk("credit_one_more", 64'(issue_cnt), 64'd9);
        chk("credit_fetch_count2", 64'(fetch_count), 64'd9);
        chk("credit_vaddr_v2", 64'(ifc.vaddr_v_o), 64'd0);
        hold = 1'b0;
        run_to_done();
        chk("credit_final_count", 64'(fetch_count), 64'd64);
        chk("credit_error", 64'(error), 64'd0);

        // Redirect coinciding with the issue of 0x80000010.
        sb_on = 1'b1;
        for (int i = 0; i < 5; i++) exp_q.push_back(39'h00_8000_0000 + 39'(4 * i));
        for (int i = 0; i < 59; i++) exp_q.push_back(39'h00_8000_1000 + 39'(4 * i));
        start = 1'b1;
        step();
        g = 0;
        while (ifc.vaddr_o != 39'h00_8000_0010 && g < 50) begin
            step();
            g++;
        end
        redirect_v     = 1'b1;
        redirect_vaddr = 39'h00_8000_1002;
        step();
        chk("redir_vaddr", 64'(ifc.vaddr_o), 64'h8000_1000);
        chk("redir_vaddr_v", 64'(ifc.vaddr_v_o), 64'd1);
        step();
        chk("redir_next", 64'(ifc.vaddr_o), 64'h8000_1004);
        run_to_done();
        chk("redir_error", 64'(error), 64'd0);
        chk("redir_fetch_count", 64'(fetch_count), 64'd64);
        chk("redir_sb_left", 64'(exp_q.size()), 64'd0);
        chk("redir_sb_extra", 64'(sb_extra), 64'd0);
        sb_on = 1'b0;

        // Two corrupted returns: only the first is recorded.
        corrupt_a = 39'h00_8000_0020;
        corrupt_b = 39'h00_8000_0030;
        start = 1'b1;
        step();
        run_to_done();
        chk("corrupt_error", 64'(error), 64'd1);
        chk("corrupt_err_vaddr", 64'(err_vaddr), 64'h8000_0020);
        chk("corrupt_fetch_count", 64'(fetch_count), 64'd64);
        corrupt_a = 39'h1;
        corrupt_b = 39'h1;

        // Spurious return with nothing outstanding.
        ifc.vaddr_ready_i = 1'b0;
        start = 1'b1;
        step();
        chk("restart_error_clear", 64'(error), 64'd0);
        chk("restart_err_vaddr_clear", 64'(err_vaddr), 64'd0);
        ifc.data_v_i = 1'b1;
        ifc.data_i   = 32'h1234_5678;
        step();
        chk("spurious_error", 64'(error), 64'd1);
        chk("spurious_err_vaddr", 64'(err_vaddr), 64'd0);

        // Redirect targets: tag derivation and uncached threshold.
        for (int i = 0; i < 5; i++) begin
            redirect_v     = 1'b1;
            redirect_vaddr = vecs[i].target;
            step();
            chk("tbl_vaddr", 64'(ifc.vaddr_o), 64'(vecs[i].exp_vaddr));
            chk("tbl_ptag", 64'(ifc.ptag_o), 64'(vecs[i].exp_ptag));
            chk("tbl_uncached", 64'(ifc.uncached_o), 64'(vecs[i].exp_unc));
            chk("tbl_vaddr_v", 64'(ifc.vaddr_v_o), 64'd1);
            chk("tbl_fetch_count", 64'(fetch_count), 64'd0);
        end
        ifc.vaddr_ready_i = 1'b1;
        step();
        ifc.vaddr_ready_i = 1'b0;
        chk("wrap_vaddr", 64'(ifc.vaddr_o), 64'd0);
        chk("wrap_ptag", 64'(ifc.ptag_o), 64'd0);
        chk("wrap_uncached", 64'(ifc.uncached_o), 64'd0);
        chk("wrap_fetch_count", 64'(fetch_count), 64'd1);
        repeat (3) step();

        // Asynchronous reset mid-run with five fetches in flight.
        hold = 1'b1;
        issue_cnt = 0;
        ifc.vaddr_ready_i = 1'b1;
        g = 0;
        while (issue_cnt < 5 && g < 20) begin
            step();
            g++;
        end
        ifc.vaddr_ready_i = 1'b0;
        chk("pre_reset_count", 64'(fetch_count), 64'd6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vaddr_v", 64'(ifc.vaddr_v_o), 64'd0);
        chk("arst_vaddr", 64'(ifc.vaddr_o), 64'd0);
        chk("arst_fetch_count", 64'(fetch_count), 64'd0);
        chk("arst_error", 64'(error), 64'd0);
        chk("arst_err_vaddr", 64'(err_vaddr), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ret_q.delete();
        hold = 1'b0;
        ifc.vaddr_ready_i = 1'b1;
        issue_cnt = 0;
        start = 1'b1;
        step();
        chk("post_reset_start", 64'(ifc.vaddr_v_o), 64'd1);
        run_to_done();
        chk("post_reset_count", 64'(fetch_count), 64'd64);
        chk("post_reset_issues", 64'(issue_cnt), 64'd64);
        chk("post_reset_error", 64'(error), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
